// File: rtl/pergate_gatefn_collect_pkg.sv
// Shared field definitions for the gatefn collector: field width, modulus and
// the modular add used by every accumulator lane.
`ifndef PERGATE_GATEFN_COLLECT_PKG_SV
`define PERGATE_GATEFN_COLLECT_PKG_SV

package pergate_gatefn_collect_pkg;

  localparam int                 F_NBITS = 8;
  localparam logic [F_NBITS-1:0] F_Q     = 8'd251;

  // Both operands are already reduced, so one conditional subtract suffices.
  function automatic logic [F_NBITS-1:0] fieldAdd(input logic [F_NBITS-1:0] a,
                                                  input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q}) fieldAdd = F_NBITS'(s - {1'b0, F_Q});
    else                  fieldAdd = s[F_NBITS-1:0];
  endfunction

endpackage

`endif

// File: rtl/pergate_gatefn_collect_lane.sv
// One evaluation-point accumulator: clear on start, modular add while collecting.
`ifndef PERGATE_GATEFN_COLLECT_LANE_SV
`define PERGATE_GATEFN_COLLECT_LANE_SV

module pergate_gatefn_collect_lane
  import pergate_gatefn_collect_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               clr_i,
  input  logic               add_en_i,
  input  logic [F_NBITS-1:0] operand_i,
  output logic [F_NBITS-1:0] acc_o
);

  logic [F_NBITS-1:0] acc_q;
  logic [F_NBITS-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)         acc_d = '0;
    else if (add_en_i) acc_d = fieldAdd(acc_q, operand_i);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

`endif

// File: rtl/pergate_gatefn_collect.sv
// Starts all per-gate gatefn units, waits until every unit is ready, then sums
// their four evaluations point by point over ngates cycles.
`ifndef PERGATE_GATEFN_COLLECT_SV
`define PERGATE_GATEFN_COLLECT_SV

module pergate_gatefn_collect
  import pergate_gatefn_collect_pkg::*;
#(
  parameter int ngates = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  output logic               ready,
  output logic               gate_en,
  input  logic [ngates-1:0]  gate_ready,
  input  logic [F_NBITS-1:0] gatefn [ngates-1:0][3:0],
  output logic [F_NBITS-1:0] sum [3:0]
);

  localparam int IW = (ngates > 1) ? $clog2(ngates) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACCUM = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            gate_en_q, gate_en_d;
  logic            clr;
  logic            add_en;
  logic [F_NBITS-1:0] operand [3:0];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      gate_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gate_en_q <= gate_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gate_en_d = 1'b0;
    clr       = 1'b0;
    add_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_WAIT;
          gate_en_d = 1'b1;
          clr       = 1'b1;
        end
      end
      ST_WAIT: begin
        if (&gate_ready) begin
          state_d = ST_ACCUM;
          idx_d   = '0;
        end
      end
      ST_ACCUM: begin
        add_en = 1'b1;
        if (idx_q == IW'(ngates - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Mux by compare so a non-power-of-two ngates never indexes past the array.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      operand[k] = '0;
      for (int i = 0; i < ngates; i++) begin
        if (idx_q == IW'(i)) operand[k] = gatefn[i][k];
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    pergate_gatefn_collect_lane u_lane (
      .clk       (clk),
      .rstb      (rstb),
      .clr_i     (clr),
      .add_en_i  (add_en),
      .operand_i (operand[k]),
      .acc_o     (sum[k])
    );
  end

  assign ready   = (state_q == ST_IDLE) & ~en;
  assign gate_en = gate_en_q;

endmodule

`endif
